// File: rtl/shift_in_pkg.sv
// Shared types and helpers for the serial-to-parallel operand capture register.
package shift_in_pkg;

   // Capture FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // A requested length of 0, or one longer than the register, means "full width".
   function automatic int clamp_len(input int len, input int width);
      if ((len == 0) || (len > width)) begin
         return width;
      end
      return len;
   endfunction

endpackage

// File: rtl/shift_in_n_if.sv
// Bundle of the serial-source / parallel-consumer signals of one shift_in_n.
//
// Hand-off rules: the register raises valid once the programmed number of
// bits has been shifted in and keeps par_out frozen while valid is high.
// The word is taken on the first rising edge where valid and ready are both
// high; valid drops after that edge. ready may be high at any time and has no
// effect while valid is low. start on the same edge as the accepting ready
// takes priority and begins a fresh capture.
interface shift_in_n_if #(
   parameter int WIDTH = 12
) ();
   import shift_in_pkg::*;

   localparam int CW = $clog2(WIDTH + 1);

   logic             start;
   logic [CW-1:0]    len;
   logic             s_in;
   logic             s_en;
   logic [WIDTH-1:0] par_out;
   logic             valid;
   logic             ready;
   logic             busy;
   logic             ovf;
   state_t           dbg_state;

   // Driver side: operand source plus multiplier consumer.
   modport master (
      output start, len, s_in, s_en, ready,
      input  par_out, valid, busy, ovf, dbg_state
   );

   // The capture register itself.
   modport slave (
      input  start, len, s_in, s_en, ready,
      output par_out, valid, busy, ovf, dbg_state
   );

endinterface

// File: rtl/shift_in_n.sv
// Serial-to-parallel operand capture register with run-time length,
// selectable bit order and a valid/ready hand-off. All outputs registered.
module shift_in_n
   import shift_in_pkg::*;
#(
   parameter int WIDTH     = 12,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   shift_in_n_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_par;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    r_len;
   logic             r_valid;
   logic             r_busy;
   logic             r_ovf;

   logic [WIDTH-1:0] w_par_shift;
   logic [CW-1:0]    w_count_inc;
   logic             w_shift;
   logic             w_last;
   logic [CW-1:0]    w_len_clamped;

   // count stays below len_q while shifting, so the increment never wraps.
   assign w_count_inc   = r_count + CW'(1);
   assign w_shift       = (r_state == SHIFT) && bus.s_en;
   assign w_last        = w_shift && (w_count_inc == r_len);
   assign w_len_clamped = CW'(clamp_len(32'(bus.len), WIDTH));

   generate
      if (LSB_FIRST) begin : g_lsb_first
         // Each new bit lands at the position given by how many bits came before it.
         always_comb begin
            w_par_shift                     = r_par;
            w_par_shift[r_count[IW-1:0]]    = bus.s_in;
         end
      end else begin : g_msb_first
         // Shift left so the first bit received ends up most significant.
         assign w_par_shift = {r_par[WIDTH-2:0], bus.s_in};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; start preempts whatever the FSM was doing.
   always_comb begin
      w_next = r_state;
      if (bus.start) begin
         w_next = SHIFT;
      end else begin
         unique case (r_state)
            IDLE:    w_next = IDLE;
            SHIFT:   if (w_last) w_next = HOLD;
            HOLD:    if (r_valid && bus.ready) w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   // Datapath and registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_par   <= '0;
         r_count <= '0;
         r_len   <= CW'(WIDTH);
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (bus.start) begin
         r_par   <= '0;
         r_count <= '0;
         r_len   <= w_len_clamped;
         r_valid <= 1'b0;
         r_busy  <= 1'b1;
         r_ovf   <= 1'b0;
      end else begin
         unique case (r_state)
            SHIFT: begin
               if (bus.s_en) begin
                  r_par   <= w_par_shift;
                  r_count <= w_count_inc;
                  if (w_last) begin
                     r_valid <= 1'b1;
                     r_busy  <= 1'b0;
                  end
               end
            end
            HOLD: begin
               // Source kept sending after the word was complete: flag the lost bit.
               if (bus.s_en) begin
                  r_ovf <= 1'b1;
               end
               if (r_valid && bus.ready) begin
                  r_valid <= 1'b0;
               end
            end
            default: begin
               // IDLE: keep the last word, ignore serial input and ready.
            end
         endcase
      end
   end

   assign bus.par_out   = r_par;
   assign bus.valid     = r_valid;
   assign bus.busy      = r_busy;
   assign bus.ovf       = r_ovf;
   assign bus.dbg_state = r_state;

endmodule

// File: doc/shift_in_n.md
# shift_in_n

Parametrised serial-to-parallel capture register for multiplier operand loading. It replaces the fixed 12-bit operand shifter with a configurable width, run-time word length, selectable bit order, and a valid/ready hand-off to the multiplier datapath. It sits between the serial operand source and the multiplier core, one instance per operand.

## Interface
- WIDTH, 12, maximum captured word width in bits (≥2)
- LSB_FIRST, 0, bit order: 0 = first serial bit ends up MSB of captured word; 1 = first bit lands at bit 0
- CW, $clog2(WIDTH+1), counter/length width (derived, not overridden)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  clear register and arm a new capture; latches len
- len  in  CW  number of bits to capture; 0 or >WIDTH treated as WIDTH
- s_in  in  1  serial data bit
- s_en  in  1  shift enable; s_in sampled on edges where s_en=1 in SHIFT
- par_out  out  WIDTH  captured word, right-aligned, upper WIDTH-len bits zero
- valid  out  1  par_out complete and stable
- ready  in  1  consumer accepts par_out when valid=1
- busy  out  1  capture in progress (state SHIFT)
- ovf  out  1  sticky: s_en seen while in HOLD (data dropped)

## Operation
- States: IDLE, SHIFT, HOLD. All outputs registered.
- Reset (rst=1 at edge): state IDLE, par_out=0, count=0, len_q=WIDTH, valid=0, busy=0, ovf=0. rst overrides every other input.
- start=1 (any state, rst=0): par_out←0, count←0, ovf←0, len_q←clamp(len), state←SHIFT. start overrides s_en, ready on the same edge; in-progress or held word is discarded.
- SHIFT, s_en=1: MSB-first: par_out←{par_out[WIDTH-2:0], s_in}; LSB-first: par_out[count]←s_in. count←count+1. s_en=0: hold all.
- When the shift makes count == len_q: state←HOLD, valid←1, busy←0 on that same edge.
- HOLD: par_out frozen. valid&ready → state IDLE, valid←0. s_en=1 in HOLD sets ovf (bit ignored).
- IDLE: s_en, s_in, ready ignored; ovf not set. par_out retains last word.
- Arithmetic: count never exceeds len_q ≤ WIDTH; no wrap. clamp(len) = WIDTH if len==0 or len>WIDTH.

## Timing
- Capture latency: valid high in the cycle immediately after the edge that samples the len_q-th enabled bit.
- Minimum start-to-valid: len_q+1 edges (start edge + len_q enabled shift edges).
- Handshake: valid stays high until the edge where ready=1; it drops on the following cycle. ready is not required to wait for valid; ready without valid is ignored.
- Back-to-back: start may be asserted on the same edge as the accepting ready; start wins, new capture begins immediately.
- s_en gaps of any length in SHIFT are legal; no timeout.

## Structure
- Package shift_in_pkg: state enum (IDLE, SHIFT, HOLD), clamp_len function.
- Single module, no sub-modules; bit-order selection by generate on LSB_FIRST.

## Test plan
- WIDTH=12, LSB_FIRST=0, len=0, start, shift 12 bits of 0xA5C MSB-first with s_en=1 → valid after 12th edge, par_out=0xA5C, busy 1→0; ready=1 → valid=0 next cycle, state IDLE.
- LSB_FIRST=1, len=8, bits 1,0,1,1,0,0,0,1 in order → par_out=0x08D, upper 4 bits 0.
- LSB_FIRST=0, len=4, s_en toggling 1/0 while sending 1,1,0,1 → par_out=0x00D only after 4th enabled edge; disabled cycles leave par_out unchanged.
- In HOLD with ready=0, pulse s_en three times → ovf=1, par_out unchanged; next start → ovf=0, par_out=0.
- After 5 of 12 bits, assert start → count reset, par_out=0, fresh 12-bit word 0x3F0 captured correctly; repeat with rst instead → all outputs at reset values, state IDLE.
- len=15 with WIDTH=12 → behaves as 12; start and ready on same edge in HOLD → new capture begins, valid=0.
